// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between fetch_unit (master) and instruction memory (slave).
// imemAddr must stay stable while imemReq=1 and imemAck=0.
interface fetch_unit_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;

    modport master (output imemReq, imemAddr, input imemAck, imemData);
    modport slave  (input imemReq, imemAddr, output imemAck, imemData);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC, req/ack imem reads, prefetch queue, STALL/FLUSH handling.
// Optional FETCH_PERF_EN adds a 32-bit bubbleCount of cycles with validOut=0.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic [31:0]       branchTarget,
    fetch_unit_if.master      imem,
    output logic              validOut,
    output logic [31:0]       PCOut,
    output logic [31:0]       instructionOut
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       bubbleCount
`endif
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, SQUASH} state_t;

    state_t          state, nstate;
    logic [31:0]     fetch_pc, addr_q;
    logic [31:0]     pc_q  [QDEPTH];
    logic [31:0]     ins_q [QDEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   cnt, cnt_after;
    logic            pushing, popping;

    assign pushing   = (state == WAIT) && imem.imemAck && !FLUSH;
    assign popping   = (cnt != '0) && !STALL && !FLUSH;
    assign cnt_after = cnt + CW'(pushing) - CW'(popping);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nstate;
    end

    // Back-to-back request only while the slot it will occupy is guaranteed free.
    always_comb begin
        nstate = state;
        case (state)
            IDLE:   if (!FLUSH && cnt < CW'(QDEPTH)) nstate = WAIT;
            WAIT: begin
                if (FLUSH)              nstate = imem.imemAck ? IDLE : SQUASH;
                else if (imem.imemAck)  nstate = (cnt_after < CW'(QDEPTH)) ? WAIT : IDLE;
            end
            SQUASH: if (imem.imemAck)   nstate = IDLE;
            default:                    nstate = IDLE;
        endcase
    end

    always_comb begin
        imem.imemReq   = (state != IDLE);
        imem.imemAddr  = addr_q;
        validOut       = (cnt != '0);
        PCOut          = validOut ? pc_q[rd_ptr]  : 32'h0;
        instructionOut = validOut ? ins_q[rd_ptr] : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            addr_q   <= 32'h0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
        end else begin
            if (FLUSH) begin
                fetch_pc <= branchTarget;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                cnt      <= '0;
            end else begin
                if (pushing) begin
                    pc_q[wr_ptr]  <= imem.imemAddr;
                    ins_q[wr_ptr] <= imem.imemData;
                    wr_ptr        <= wr_ptr + AW'(1);
                    fetch_pc      <= fetch_pc + PC_INC;
                end
                if (popping) rd_ptr <= rd_ptr + AW'(1);
                cnt <= cnt_after;
            end
            // addr_q only moves when a new request starts; held through WAIT and SQUASH.
            if (state == IDLE && nstate == WAIT)
                addr_q <= fetch_pc;
            else if (pushing && nstate == WAIT)
                addr_q <= fetch_pc + PC_INC;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst)          bubbleCount <= 32'h0;
        else if (!validOut) bubbleCount <= bubbleCount + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/fill, flush variants, slow memory, reset and PC wrap.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, STALL, FLUSH;
    logic [31:0] branchTarget;
    logic        validOut;
    logic [31:0] PCOut, instructionOut;
    int          lat;
    int          wcnt;
    int          total = 0;
    int          bad   = 0;

    fetch_unit_if bus();

`ifdef FETCH_PERF_EN
    logic [31:0] bubbleCount;
    logic [31:0] exp_bub;
`endif

    fetch_unit dut (
        .clk(clk), .rst(rst), .STALL(STALL), .FLUSH(FLUSH), .branchTarget(branchTarget),
        .imem(bus.master), .validOut(validOut), .PCOut(PCOut), .instructionOut(instructionOut)
`ifdef FETCH_PERF_EN
        , .bubbleCount(bubbleCount)
`endif
    );

    always #5 clk = ~clk;

    // Memory returns the address as data; ack after the request has waited lat cycles.
    assign bus.imemAck  = bus.imemReq && (wcnt >= lat);
    assign bus.imemData = bus.imemAddr;
    always @(posedge clk) begin
        if (!bus.imemReq || bus.imemAck) wcnt <= 0;
        else                             wcnt <= wcnt + 1;
    end

`ifdef FETCH_PERF_EN
    always @(posedge clk) begin
        if (!rst)           exp_bub <= 32'h0;
        else if (!validOut) exp_bub <= exp_bub + 32'd1;
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_v"},  {31'h0, validOut}, 32'h1);
        chk({tag, "_pc"}, PCOut, pc);
        chk({tag, "_in"}, instructionOut, pc);
    endtask

    initial begin
        wcnt = 0; lat = 0;
        rst = 1'b0; STALL = 1'b0; FLUSH = 1'b0; branchTarget = 32'h0;
        tick(); tick();
        chk("rst_v",   {31'h0, validOut}, 32'h0);
        chk("rst_pc",  PCOut, 32'h0);
        chk("rst_in",  instructionOut, 32'h0);
        chk("rst_req", {31'h0, bus.imemReq}, 32'h0);
        chk("rst_adr", bus.imemAddr, 32'h0);

        // streaming with zero-wait memory
        rst = 1'b1;
        tick();
        chk("t1_req", {31'h0, bus.imemReq}, 32'h1);
        chk("t1_adr", bus.imemAddr, 32'h0);
        chk("t1_v0",  {31'h0, validOut}, 32'h0);
        tick(); chk_head("t1_a", 32'h0);
        tick(); chk_head("t1_b", 32'h4);
        tick(); chk_head("t1_c", 32'h8);
        tick(); chk_head("t1_d", 32'hC);

        // stall fills the queue, request drops, order kept after release
        STALL = 1'b1;
        tick(); chk_head("t2_s1", 32'hC);
        tick(); chk_head("t2_s2", 32'hC);
        tick(); chk_head("t2_s3", 32'hC);
        chk("t2_req_full", {31'h0, bus.imemReq}, 32'h0);
        STALL = 1'b0;
        tick(); chk_head("t2_r1", 32'h10);
        chk("t2_req_idle", {31'h0, bus.imemReq}, 32'h0);
        tick(); chk_head("t2_r2", 32'h14);
        chk("t2_adr", bus.imemAddr, 32'h1C);
        tick(); chk_head("t2_r3", 32'h18);
        tick(); chk_head("t2_r4", 32'h1C);

        // flush in WAIT, ack arrives two cycles later and is discarded
        lat = 2; FLUSH = 1'b1; branchTarget = 32'h100;
        tick();
        FLUSH = 1'b0;
        chk("t3_v0",   {31'h0, validOut}, 32'h0);
        chk("t3_pc0",  PCOut, 32'h0);
        chk("t3_req",  {31'h0, bus.imemReq}, 32'h1);
        chk("t3_adr",  bus.imemAddr, 32'h24);
        tick();
        chk("t3_adr_hold", bus.imemAddr, 32'h24);
        tick();
        chk("t3_idle", {31'h0, bus.imemReq}, 32'h0);
        chk("t3_v1",   {31'h0, validOut}, 32'h0);
        tick();
        chk("t3_radr", bus.imemAddr, 32'h100);
        lat = 0;
        tick(); chk_head("t3_h0", 32'h100);
        tick(); chk_head("t3_h1", 32'h104);

        // flush with ack in the same cycle
        FLUSH = 1'b1; branchTarget = 32'h200;
        tick();
        FLUSH = 1'b0;
        chk("t4a_v",   {31'h0, validOut}, 32'h0);
        chk("t4a_req", {31'h0, bus.imemReq}, 32'h0);
        tick();
        chk("t4a_adr", bus.imemAddr, 32'h200);
        tick(); chk_head("t4a_h", 32'h200);

        // stall and flush together
        STALL = 1'b1; FLUSH = 1'b1; branchTarget = 32'h300;
        tick();
        STALL = 1'b0; FLUSH = 1'b0;
        chk("t4b_v",   {31'h0, validOut}, 32'h0);
        chk("t4b_in",  instructionOut, 32'h0);
        tick();
        chk("t4b_adr", bus.imemAddr, 32'h300);
        tick(); chk_head("t4b_h", 32'h300);

        // 3-cycle memory: address stable, one instruction per 4 cycles
        lat = 3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_adr", bus.imemAddr, 32'h304);
            chk("t5_v0",  {31'h0, validOut}, 32'h0);
        end
        tick(); chk_head("t5_h0", 32'h304);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_adr2", bus.imemAddr, 32'h308);
            chk("t5_v1",   {31'h0, validOut}, 32'h0);
        end
        tick(); chk_head("t5_h1", 32'h308);

        // reset in the middle of a WAIT
        rst = 1'b0;
        tick();
        rst = 1'b1; lat = 0;
        chk("t6_req", {31'h0, bus.imemReq}, 32'h0);
        chk("t6_adr", bus.imemAddr, 32'h0);
        chk("t6_v",   {31'h0, validOut}, 32'h0);
        chk("t6_pc",  PCOut, 32'h0);
        tick();
        chk("t6_radr", bus.imemAddr, 32'h0);
        tick(); chk_head("t6_h", 32'h0);

        // PC wrap at the top of the address space
        FLUSH = 1'b1; branchTarget = 32'hFFFF_FFFC;
        tick();
        FLUSH = 1'b0;
        tick();
        chk("t6_wadr", bus.imemAddr, 32'hFFFF_FFFC);
        tick(); chk_head("t6_w0", 32'hFFFF_FFFC);
        tick(); chk_head("t6_w1", 32'h0);

`ifdef FETCH_PERF_EN
        chk("bubbles", bubbleCount, exp_bub);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
